// File: rtl/serial_responder_pkg.sv
// Shared definitions for the serial flit responder: field offsets, flit and
// frame width helpers, FSM state encodings and a saturating counter helper.
// Optional feature macro: SERIAL_RESPONDER_PARITY_EN (even parity bit per frame).
`ifndef SIZE
`define SIZE 4
`endif

package serial_responder_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_e;

  // Transmit FSM states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_e;

  localparam int CNT_W = 16;

  // Flit layout, LSB first on the line: payload, dst, src
  localparam int PAYLOAD_LSB = 0;

  function automatic int dst_lsb(input int payload_w);
    return PAYLOAD_LSB + payload_w;
  endfunction

  function automatic int src_lsb(input int addr_w, input int payload_w);
    return PAYLOAD_LSB + payload_w + addr_w;
  endfunction

  // Number of data bits in a flit
  function automatic int flit_w(input int addr_w, input int payload_w);
    return 2 * addr_w + payload_w;
  endfunction

  // Number of bits following the start bit on the line
  function automatic int frame_bits(input int addr_w, input int payload_w);
`ifdef SERIAL_RESPONDER_PARITY_EN
    return flit_w(addr_w, payload_w) + 1;
`else
    return flit_w(addr_w, payload_w);
`endif
  endfunction

  // Event counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/serial_flit_tx.sv
// Reply serializer: start bit, then the flit LSB first, plus an even parity
// bit when SERIAL_RESPONDER_PARITY_EN is defined. Backpressure is honoured
// only before the start bit; a started frame always runs to completion.
module serial_flit_tx
  import serial_responder_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int PAYLOAD_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reply_valid_i,
  input  logic [2*ADDR_W+PAYLOAD_W-1:0] reply_i,
  input  logic                          tx_busy_i,
  output logic                          tx_data_o,
  output logic                          tx_done_o
);

  localparam int F   = flit_w(ADDR_W, PAYLOAD_W);
  localparam int TXW = frame_bits(ADDR_W, PAYLOAD_W);
  localparam int BCW = $clog2(TXW + 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [BCW-1:0]   tx_bit_q, tx_bit_d;
  logic [TXW-1:0]   tx_shift_q, tx_shift_d;
  logic             tx_data_q, tx_data_d;
  logic [TXW-1:0]   frame;
  logic             last_bit;

`ifdef SERIAL_RESPONDER_PARITY_EN
  assign frame = {^reply_i, reply_i};
`else
  assign frame = reply_i;
`endif

  // tx_bit_q is the index of the bit currently on the line
  assign last_bit  = (tx_state_q == TX_SHIFT) && (tx_bit_q == BCW'(TXW - 1));
  assign tx_done_o = last_bit;
  assign tx_data_o = tx_data_q;

  // Next-state logic; tx_data is computed from the next state so the line is registered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_data_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (reply_valid_i && !tx_busy_i) begin
          tx_state_d = TX_START;
          tx_shift_d = frame;
          tx_data_d  = 1'b1;
        end
      end
      TX_START: begin
        tx_state_d = TX_SHIFT;
        tx_bit_d   = '0;
        tx_data_d  = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
      end
      TX_SHIFT: begin
        if (last_bit) begin
          tx_state_d = TX_IDLE;
          tx_data_d  = 1'b0;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_data_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_data_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // F is only used through the port width
  localparam int UNUSED_F = F;

endmodule

// File: rtl/serial_responder.sv
// Serial flit responder: deserializes incoming flits, answers flits addressed
// to ID with {src=ID, dst=rx.src, payload+1}, and counts accepted, replied
// and dropped flits. Holds a single reply; rx_busy stalls the link meanwhile.
// Optional feature macro: SERIAL_RESPONDER_PARITY_EN (even parity per frame).
module serial_responder
  import serial_responder_pkg::*;
#(
  parameter int ID        = 0,
  parameter int ADDR_W    = `SIZE,
  parameter int PAYLOAD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_data,
  output logic              rx_busy,
  output logic              tx_data,
  input  logic              tx_busy,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int F       = flit_w(ADDR_W, PAYLOAD_W);
  localparam int RXW     = frame_bits(ADDR_W, PAYLOAD_W);
  localparam int BCW     = $clog2(RXW + 1);
  localparam int DST_LSB = dst_lsb(PAYLOAD_W);
  localparam int SRC_LSB = src_lsb(ADDR_W, PAYLOAD_W);

  rx_state_e         rx_state_q, rx_state_d;
  logic [BCW-1:0]    rx_bit_q, rx_bit_d;
  logic [RXW-1:0]    rx_shift_q, rx_shift_d;
  logic [F-1:0]      reply_q, reply_d;
  logic              reply_valid_q, reply_valid_d;
  logic              rx_busy_q, rx_busy_d;
  logic [CNT_W-1:0]  rx_count_q, rx_count_d;
  logic [CNT_W-1:0]  tx_count_q, tx_count_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic                 tx_done;
  logic [F-1:0]         rx_flit;
  logic [ADDR_W-1:0]    rx_dst;
  logic [ADDR_W-1:0]    rx_src;
  logic [PAYLOAD_W-1:0] rx_payload;
  logic [ADDR_W-1:0]    id_addr;
  logic                 parity_ok;
  logic [F-1:0]         reply_flit;

  // Field extraction from the fully shifted-in frame
  assign rx_flit    = rx_shift_q[F-1:0];
  assign rx_payload = rx_flit[PAYLOAD_LSB +: PAYLOAD_W];
  assign rx_dst     = rx_flit[DST_LSB +: ADDR_W];
  assign rx_src     = rx_flit[SRC_LSB +: ADDR_W];
  assign id_addr    = ADDR_W'(ID);

`ifdef SERIAL_RESPONDER_PARITY_EN
  // Even parity: the parity bit equals the XOR of the data bits
  assign parity_ok = (rx_shift_q[F] == ^rx_flit);
`else
  assign parity_ok = 1'b1;
`endif

  // Reply keeps the payload+1 and swaps the addresses; concat order is src, dst, payload
  assign reply_flit = {id_addr, rx_src, PAYLOAD_W'(rx_payload + 1'b1)};

  // RX FSM, reply buffer and counter next-state logic
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    reply_d       = reply_q;
    reply_valid_d = reply_valid_q;
    rx_count_d    = rx_count_q;
    tx_count_d    = tx_count_q;
    drop_count_d  = drop_count_q;

    if (tx_done) begin
      reply_valid_d = 1'b0;
      tx_count_d    = sat_inc(tx_count_q);
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_data && !rx_busy_q) begin
          rx_state_d = RX_SHIFT;
          rx_bit_d   = '0;
        end
      end
      RX_SHIFT: begin
        // Every bit here is data (or parity), even a 1
        rx_shift_d = {rx_data, rx_shift_q[RXW-1:1]};
        if (rx_bit_q == BCW'(RXW - 1)) begin
          rx_state_d = RX_CHECK;
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      RX_CHECK: begin
        rx_state_d = RX_IDLE;
        if (parity_ok && (rx_dst == id_addr)) begin
          reply_d       = reply_flit;
          reply_valid_d = 1'b1;
          rx_count_d    = sat_inc(rx_count_q);
        end else begin
          drop_count_d = sat_inc(drop_count_q);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Registered so rx_busy_q equals reply_valid_q | (rx_state_q != RX_IDLE)
    rx_busy_d = reply_valid_d | (rx_state_d != RX_IDLE);
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      reply_q       <= '0;
      reply_valid_q <= 1'b0;
      rx_busy_q     <= 1'b0;
      rx_count_q    <= '0;
      tx_count_q    <= '0;
      drop_count_q  <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
      rx_busy_q     <= rx_busy_d;
      rx_count_q    <= rx_count_d;
      tx_count_q    <= tx_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  serial_flit_tx #(
    .ADDR_W    (ADDR_W),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_tx (
    .clk           (clk),
    .reset         (reset),
    .reply_valid_i (reply_valid_q),
    .reply_i       (reply_q),
    .tx_busy_i     (tx_busy),
    .tx_data_o     (tx_data),
    .tx_done_o     (tx_done)
  );

  assign rx_busy    = rx_busy_q;
  assign rx_count   = rx_count_q;
  assign tx_count   = tx_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_serial_responder.sv
// Bench for serial_responder (ID=4, ADDR_W=4, PAYLOAD_W=8): a monitor
// deserializes replies and compares them against a queue of expected flits;
// a vector table drives ordinary requests, hand sequences cover timing,
// backpressure, reset mid-reply and (with SERIAL_RESPONDER_PARITY_EN) parity.
`timescale 1ns/1ps
module tb_serial_responder;

  localparam int AW    = 4;
  localparam int PW    = 8;
  localparam int F     = 2 * AW + PW;
  localparam int MY_ID = 4;
`ifdef SERIAL_RESPONDER_PARITY_EN
  localparam int FW = F + 1;
`else
  localparam int FW = F;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_data = 1'b0;
  logic        tx_busy = 1'b0;
  logic        rx_busy;
  logic        tx_data;
  logic [15:0] rx_count;
  logic [15:0] tx_count;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;
  int exp_rx = 0;
  int exp_tx = 0;
  int exp_drop = 0;
  bit mon_busy = 1'b0;
  logic [F-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [PW-1:0] payload;
  } vec_t;

  vec_t vecs[6];

  serial_responder #(
    .ID        (MY_ID),
    .ADDR_W    (AW),
    .PAYLOAD_W (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_busy    (rx_busy),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, req);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rx_count"}, 32'(rx_count), 32'(exp_rx));
    check({tag, "_tx_count"}, 32'(tx_count), 32'(exp_tx));
    check({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
  endtask

  // Expected reply: addresses swapped, payload incremented with wrap
  function automatic logic [F-1:0] model_reply(input logic [AW-1:0] src, input logic [PW-1:0] pl);
    logic [PW-1:0] np;
    np = pl + 8'd1;
    return {4'(MY_ID), src, np};
  endfunction

  // Drive one frame; returns 1ns after the edge that samples the last bit
  task automatic send(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                      input logic [PW-1:0] pl, input bit flip_par);
    logic [F-1:0] flit;
    int n;
    flit = {src, dst, pl};
    n = 0;
    while (rx_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_wait_rx_busy", 32'(rx_busy), 32'd0);
    @(posedge clk); #1 rx_data = 1'b1;
    for (int i = 0; i < F; i++) begin
      @(posedge clk); #1 rx_data = flit[i];
    end
`ifdef SERIAL_RESPONDER_PARITY_EN
    @(posedge clk); #1 rx_data = (^flit) ^ flip_par;
`else
    if (flip_par) $display("note: parity flip has no effect without parity");
`endif
    @(posedge clk); #1 rx_data = 1'b0;
    $display("sent src=%0d dst=%0d payload=0x%02h", src, dst, pl);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((rx_busy !== 1'b0 || tx_data !== 1'b0 || mon_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s: got=timeout expected=idle within 200 cycles", name);
    end
    @(negedge clk);
  endtask

  // Reply monitor: captures each frame and checks it against the scoreboard
  initial begin
    logic [FW-1:0] bits;
    logic [F-1:0]  e;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx_data === 1'b1) begin
        mon_busy = 1'b1;
        aborted = 1'b0;
        bits = '0;
        for (int i = 0; i < FW; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          bits[i] = tx_data;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_reply: got=0x%0h expected=no reply", bits);
          end else begin
            e = exp_q.pop_front();
            check("reply_flit", 32'(bits[F-1:0]), 32'(e));
`ifdef SERIAL_RESPONDER_PARITY_EN
            check("reply_parity", 32'(bits[F]), 32'(^e));
`endif
            $display("reply src=%0d dst=%0d payload=0x%02h", bits[15:12], bits[11:8], bits[7:0]);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    logic all_busy;
    int n;

    vecs[0] = '{src: 4'd1,  dst: 4'd4, payload: 8'h10};
    vecs[1] = '{src: 4'd3,  dst: 4'd4, payload: 8'hFF};
    vecs[2] = '{src: 4'd7,  dst: 4'd3, payload: 8'h11};
    vecs[3] = '{src: 4'd15, dst: 4'd4, payload: 8'h80};
    vecs[4] = '{src: 4'd5,  dst: 4'd9, payload: 8'h00};
    vecs[5] = '{src: 4'd4,  dst: 4'd4, payload: 8'h7F};

    // Reset state
    rx_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check_counts("reset");
    @(posedge clk); #1 reset = 1'b0; rx_data = 1'b0;
    @(negedge clk);
    check("idle_rx_busy", 32'(rx_busy), 32'd0);

    // Single request with reply latency
    exp_q.push_back(model_reply(4'd0, 8'h2A));
    exp_rx++; exp_tx++;
    send(4'd0, 4'd4, 8'h2A, 1'b0);
    @(negedge clk);
    check("single_busy_in_check", 32'(rx_busy), 32'd1);
    check("single_tx_before_check", 32'(tx_data), 32'd0);
    @(negedge clk);
    check("single_tx_no_early_start", 32'(tx_data), 32'd0);
    @(negedge clk);
    check("single_start_latency", 32'(tx_data), 32'd1);
    wait_idle("single_idle");
    check_counts("single");

    // Wrong destination: dropped, busy falls after the check cycle
    exp_drop++;
    send(4'd0, 4'd3, 8'h55, 1'b0);
    @(negedge clk);
    check("drop_busy_in_check", 32'(rx_busy), 32'd1);
    @(negedge clk);
    check("drop_busy_fall", 32'(rx_busy), 32'd0);
    check("drop_count_now", 32'(drop_count), 32'(exp_drop));
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | tx_data;
    end
    check("drop_no_reply", 32'(seen), 32'd0);
    check_counts("drop");

    // Backpressure: reply held while tx_busy is high
    tx_busy = 1'b1;
    exp_q.push_back(model_reply(4'd2, 8'h10));
    exp_rx++; exp_tx++;
    send(4'd2, 4'd4, 8'h10, 1'b0);
    @(negedge clk);
    seen = 1'b0;
    all_busy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      seen = seen | tx_data;
      all_busy = all_busy & rx_busy;
    end
    check("bp_tx_held_low", 32'(seen), 32'd0);
    check("bp_rx_busy_held", 32'(all_busy), 32'd1);
    @(posedge clk); #1 tx_busy = 1'b0;
    @(negedge clk);
    check("bp_no_start_yet", 32'(tx_data), 32'd0);
    @(negedge clk);
    check("bp_start_after_release", 32'(tx_data), 32'd1);
    wait_idle("bp_idle");
    check_counts("bp");

    // Vector table
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].dst == 4'(MY_ID)) begin
        exp_q.push_back(model_reply(vecs[v].src, vecs[v].payload));
        exp_rx++; exp_tx++;
      end else begin
        exp_drop++;
      end
      send(vecs[v].src, vecs[v].dst, vecs[v].payload, 1'b0);
      wait_idle("vec_idle");
      check_counts("vec");
    end

    // Reset during bit 5 of a reply
    exp_q.push_back(model_reply(4'd1, 8'h33));
    send(4'd1, 4'd4, 8'h33, 1'b0);
    n = 0;
    while (tx_data !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_reply_started", 32'(tx_data), 32'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_rx = 0; exp_tx = 0; exp_drop = 0;
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check_counts("rst");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.push_back(model_reply(4'd6, 8'h01));
    exp_rx++; exp_tx++;
    send(4'd6, 4'd4, 8'h01, 1'b0);
    wait_idle("post_rst_idle");
    check_counts("post_rst");

`ifdef SERIAL_RESPONDER_PARITY_EN
    // Bad parity is dropped even when addressed here; a good one is answered
    exp_drop++;
    send(4'd0, 4'd4, 8'h5A, 1'b1);
    wait_idle("par_bad_idle");
    check_counts("par_bad");
    exp_q.push_back(model_reply(4'd9, 8'h5A));
    exp_rx++; exp_tx++;
    send(4'd9, 4'd4, 8'h5A, 1'b0);
    wait_idle("par_good_idle");
    check_counts("par_good");
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_responder.md
# serial_responder

Network-side responder for the single-bit serial flit link driven by `serial_source`. It attaches to a router's local port in place of a sink and deserializes each incoming flit. When the flit is addressed to this node, it returns a reply flit to the originating node: same payload plus one, source and destination swapped. It gives the NoC a closed request/response loop for latency and integrity testing.

## Interface
- `ID`, 0, node address of this responder; compared against the flit destination field.
- `ADDR_W`, `` `SIZE ``, width of the source and destination fields.
- `PAYLOAD_W`, 8, width of the payload field.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; synchronous and active-high.
- `rx_data`  in  1  serial flit input from the router local output.
- `rx_busy`  out  1  backpressure to the router; high means "do not start a frame".
- `tx_data`  out  1  serial reply output to the router local input.
- `tx_busy`  in  1  backpressure from the router.
- `rx_count`  out  16  flits accepted for this node.
- `tx_count`  out  16  reply flits fully transmitted.
- `drop_count`  out  16  flits discarded: wrong destination, or parity error when enabled.

## Operation
- Frame format on the line:
  - Idle level is 0.
  - One start bit of value 1.
  - Then F = 2·ADDR_W + PAYLOAD_W data bits, LSB first, in the order payload, dst, src.
  - With parity enabled, one extra bit follows the data bits.
- RX FSM: RX_IDLE → RX_SHIFT → RX_CHECK → RX_IDLE.
  - RX_IDLE → RX_SHIFT on a sampled `rx_data`=1 while `rx_busy`=0.
  - RX_SHIFT samples exactly F bits (F+1 with parity). A 1 seen on the line during RX_SHIFT is data, never a new start bit.
  - RX_CHECK lasts one cycle.
    - If dst==ID: load the reply register with {src=ID, dst=rx.src, payload=rx.payload+1 mod 2^PAYLOAD_W}, set `reply_valid`, and increment `rx_count`.
    - Otherwise: increment `drop_count` and load nothing.
- `rx_busy` = `reply_valid` OR (RX state ≠ RX_IDLE). The buffer is one entry, so it holds at most one outstanding reply.
- TX FSM: TX_IDLE → TX_START → TX_SHIFT → TX_IDLE.
  - TX_IDLE → TX_START when `reply_valid`=1 and `tx_busy`=0, both sampled in the same cycle.
  - TX_START drives `tx_data`=1 for one cycle.
  - TX_SHIFT drives the bits LSB first, one per cycle.
  - After the last bit the FSM clears `reply_valid`, increments `tx_count`, and returns to TX_IDLE with `tx_data`=0.
- `tx_busy` is checked only before the start bit. Once a frame has started it is never paused.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `rx_data` sampling is ignored; `rx_busy`=0, `tx_data`=0, all counters 0, both FSMs idle, `reply_valid`=0. Reset asserted mid-frame aborts RX and TX immediately, and any reply is lost.
- `tx_data` and `rx_busy` are registered outputs.
- Latency: the last data (or parity) bit is sampled at edge N. RX_CHECK occurs at edge N+1 and the start bit appears on `tx_data` after edge N+2 if `tx_busy`=0. The full reply occupies F+1 cycles (F+2 with parity).
- `rx_busy` rises the cycle after the start bit is sampled. It falls the cycle after the reply's last bit, or after RX_CHECK when the flit is dropped.
- Incrementing `rx_count` or `drop_count` in the same cycle as `tx_count` updates both.

## Configuration
- `SERIAL_RESPONDER_PARITY_EN` defined:
  - Each frame carries an even-parity bit over the F data bits.
  - In RX, a parity mismatch takes precedence over the destination check: the flit is dropped and `drop_count` increments.
  - TX appends the correct parity bit to every reply.
- Undefined: no parity bit in either direction; frames are F data bits long.

## Structure
- The shared package/include holds the field offsets (PAYLOAD_LSB, DST_LSB, SRC_LSB), the flit-width function F, and the RX/TX state encodings.
- There is one natural sub-module, `serial_flit_tx`, which contains the TX FSM, shift register, and parity generator. The top level keeps the RX FSM, reply register, and counters.

## Test plan
All scenarios use ID=4, ADDR_W=4, PAYLOAD_W=8, parity off unless stated.
- Single request: flit src=0, dst=4, payload=0x2A.
  - Reply: src=4, dst=0, payload=0x2B.
  - Reply start bit appears 2 cycles after the last input bit.
  - Final counts: `rx_count`=1, `tx_count`=1.
- Wrong destination: dst=3.
  - No reply is sent.
  - `drop_count`=1, and `rx_busy` falls after RX_CHECK.
- Backpressure: hold `tx_busy`=1 for 10 cycles after RX_CHECK.
  - `tx_data` stays 0 and `rx_busy` stays 1.
  - The start bit follows the first cycle with `tx_busy`=0.
- Wrap: payload=0xFF yields reply payload 0x00.
- Reset mid-frame: assert `reset` during bit 5 of the reply.
  - All outputs are 0 on the next cycle.
  - A following request is served normally.
- Parity (macro on): send a flit with a flipped parity bit.
  - `drop_count`=1 and no reply.
  - A correct flit is then answered with a valid parity bit.
